// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter and sequencer that time-shares one combinational array
// multiplier among four requesters, holding each product under valid/ack.
module mult_rr_arbiter #(
    parameter int SIZE       = 16,
    parameter int MUL_CYCLES = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [3:0]          iReq,
    input  logic [4*SIZE-1:0]   iOpA,
    input  logic [4*SIZE-1:0]   iOpB,
    output logic [3:0]          oGrant,
    output logic [SIZE-1:0]     oMulA,
    output logic [SIZE-1:0]     oMulB,
    input  logic [2*SIZE-1:0]   iMulR,
    output logic [2*SIZE-1:0]   oResult,
    output logic [1:0]          oId,
    output logic                oValid,
    input  logic                iAck,
    output logic                oBusy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [7:0] count;
    logic [1:0] last;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;

    // Search last+1 .. last+4 (wrapping) so the previous winner comes last.
    always_comb begin
        found  = 1'b0;
        winner = last;
        cand   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!found && iReq[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            count   <= 8'd0;
            last    <= 2'd3;
            oGrant  <= 4'd0;
            oMulA   <= '0;
            oMulB   <= '0;
            oResult <= '0;
            oId     <= 2'd0;
            oValid  <= 1'b0;
        end else begin
            oGrant <= 4'd0;
            case (state)
                IDLE: begin
                    if (found) begin
                        oMulA  <= iOpA[winner*SIZE +: SIZE];
                        oMulB  <= iOpB[winner*SIZE +: SIZE];
                        oId    <= winner;
                        last   <= winner;
                        oGrant <= 4'b0001 << winner;
                        count  <= 8'(MUL_CYCLES - 1);
                        state  <= WAIT;
                    end
                end
                // Operands stay on the multiplier inputs until the next grant.
                WAIT: begin
                    if (count == 8'd0) begin
                        oResult <= iMulR;
                        oValid  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                DONE: begin
                    if (iAck) begin
                        oValid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oBusy = (state != IDLE);

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Scoreboard bench for mult_rr_arbiter: one instance with a single settle cycle
// and one with four, each fed by a behavioural multiplier.
module tb_mult_rr_arbiter;

    localparam int SIZE = 16;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] res;
    } resultT;

    logic        Clock;
    logic        Reset;
    logic [3:0]  iReq;
    logic [63:0] iOpA;
    logic [63:0] iOpB;
    logic        iAck;

    logic [3:0]  oGrant1, oGrant4;
    logic [15:0] oMulA1, oMulB1, oMulA4, oMulB4;
    logic [31:0] mulR1, mulR4, oResult1, oResult4;
    logic [1:0]  oId1, oId4;
    logic        oValid1, oValid4, oBusy1, oBusy4;

    int nCompared   = 0;
    int nMismatched = 0;
    logic   [3:0] grantQ[$];
    resultT       resQ[$];
    logic         monEn     = 1'b0;
    logic         prevValid = 1'b0;
    int           nWait;

    assign mulR1 = 32'(oMulA1) * 32'(oMulB1);
    assign mulR4 = 32'(oMulA4) * 32'(oMulB4);

    mult_rr_arbiter #(.SIZE(SIZE), .MUL_CYCLES(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .iReq(iReq), .iOpA(iOpA), .iOpB(iOpB),
        .oGrant(oGrant1), .oMulA(oMulA1), .oMulB(oMulB1), .iMulR(mulR1),
        .oResult(oResult1), .oId(oId1), .oValid(oValid1), .iAck(iAck), .oBusy(oBusy1)
    );

    mult_rr_arbiter #(.SIZE(SIZE), .MUL_CYCLES(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .iReq(iReq), .iOpA(iOpA), .iOpB(iOpB),
        .oGrant(oGrant4), .oMulA(oMulA4), .oMulB(oMulB4), .iMulR(mulR4),
        .oResult(oResult4), .oId(oId4), .oValid(oValid4), .iAck(iAck), .oBusy(oBusy4)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    function automatic logic [63:0] packOps(input logic [15:0] v0, v1, v2, v3);
        return {v3, v2, v1, v0};
    endfunction

    task automatic applyStimulus(input logic [3:0] req, input logic [63:0] a, input logic [63:0] b);
        iReq = req;
        iOpA = a;
        iOpB = b;
    endtask

    task automatic expectOp(input logic [1:0] id, input logic [31:0] res);
        resultT r;
        r.id  = id;
        r.res = res;
        grantQ.push_back(4'b0001 << id);
        resQ.push_back(r);
    endtask

    task automatic doReset();
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
        grantQ.delete();
        resQ.delete();
    endtask

    task automatic waitGrants(input int budget);
        for (int i = 0; i < budget && grantQ.size() != 0; i++) tick(1);
        checkOutput("grant timeout", 64'(grantQ.size()), 64'd0);
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && (resQ.size() != 0 || grantQ.size() != 0); i++) tick(1);
        checkOutput("result timeout", 64'(resQ.size() + grantQ.size()), 64'd0);
    endtask

    // Scoreboard monitor for the single-cycle instance, sampled mid-cycle.
    always @(negedge Clock) begin
        if (monEn) begin
            if (oGrant1 != 4'd0) begin
                if (grantQ.size() == 0) checkOutput("spurious grant", 64'(oGrant1), 64'd0);
                else checkOutput("grant order", 64'(oGrant1), 64'(grantQ.pop_front()));
            end
            if (oValid1 && !prevValid) begin
                if (resQ.size() == 0) begin
                    checkOutput("unexpected result", 64'(oResult1), 64'd0);
                end else begin
                    resultT r;
                    r = resQ.pop_front();
                    checkOutput("sb result", 64'(oResult1), 64'(r.res));
                    checkOutput("sb id", 64'(oId1), 64'(r.id));
                end
            end
        end
        prevValid = oValid1;
    end

    initial begin
        Reset = 1'b1;
        iAck  = 1'b1;
        applyStimulus(4'd0, 64'd0, 64'd0);
        tick(2);
        checkOutput("rst grant", 64'(oGrant1), 64'd0);
        checkOutput("rst mulA", 64'(oMulA1), 64'd0);
        checkOutput("rst mulB", 64'(oMulB1), 64'd0);
        checkOutput("rst result", 64'(oResult1), 64'd0);
        checkOutput("rst id", 64'(oId1), 64'd0);
        checkOutput("rst valid", 64'(oValid1), 64'd0);
        checkOutput("rst busy", 64'(oBusy1), 64'd0);
        Reset = 1'b0;
        monEn = 1'b1;

        $display("[TB] single request");
        expectOp(2'd1, 32'd2100);
        applyStimulus(4'b0010, packOps(16'd0, 16'd300, 16'd0, 16'd0), packOps(16'd0, 16'd7, 16'd0, 16'd0));
        tick(1);
        checkOutput("single grant", 64'(oGrant1), 64'b0010);
        checkOutput("single busy", 64'(oBusy1), 64'd1);
        iReq = 4'd0;
        tick(1);
        checkOutput("single valid", 64'(oValid1), 64'd1);
        checkOutput("single result", 64'(oResult1), 64'd2100);
        checkOutput("single id", 64'(oId1), 64'd1);
        waitDrain(10);

        $display("[TB] round robin");
        doReset();
        for (int k = 0; k < 5; k++) expectOp(2'(k), 32'(((k % 4) + 1) * 2));
        applyStimulus(4'b1111, packOps(16'd1, 16'd2, 16'd3, 16'd4), packOps(16'd2, 16'd2, 16'd2, 16'd2));
        waitGrants(40);
        iReq = 4'd0;
        waitDrain(10);

        $display("[TB] fairness");
        doReset();
        expectOp(2'd2, 32'd6);
        iReq = 4'b0100;
        waitGrants(10);
        expectOp(2'd3, 32'd8);
        expectOp(2'd0, 32'd2);
        iReq = 4'b1001;
        waitGrants(20);
        iReq = 4'd0;
        waitDrain(10);

        $display("[TB] backpressure");
        iAck = 1'b0;
        expectOp(2'd1, 32'd4);
        iReq = 4'b1111;
        waitGrants(10);
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp valid", 64'(oValid1), 64'd1);
            checkOutput("bp result", 64'(oResult1), 64'd4);
            checkOutput("bp id", 64'(oId1), 64'd1);
            checkOutput("bp no grant", 64'(oGrant1), 64'd0);
            tick(1);
        end
        expectOp(2'd2, 32'd6);
        iAck = 1'b1;
        tick(1);
        checkOutput("bp valid cleared", 64'(oValid1), 64'd0);
        tick(1);
        checkOutput("bp next grant", 64'(oGrant1), 64'b0100);
        iReq = 4'd0;
        waitDrain(10);

        $display("[TB] settle and width");
        doReset();
        expectOp(2'd0, 32'hFFFE0001);
        applyStimulus(4'b0001, packOps(16'hFFFF, 16'd0, 16'd0, 16'd0), packOps(16'hFFFF, 16'd0, 16'd0, 16'd0));
        for (int i = 0; i < 10 && oGrant4 == 4'd0; i++) tick(1);
        checkOutput("settle grant", 64'(oGrant4), 64'b0001);
        iReq = 4'd0;
        nWait = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (oValid4) begin
                nWait = i;
                break;
            end
        end
        checkOutput("settle edges", 64'(nWait), 64'd4);
        checkOutput("settle result", 64'(oResult4), 64'hFFFE0001);
        checkOutput("settle id", 64'(oId4), 64'd0);
        waitDrain(10);
        tick(2);

        $display("[TB] reset mid-operation");
        monEn = 1'b0;
        iReq = 4'b1111;
        for (int i = 0; i < 10 && oGrant4 == 4'd0; i++) tick(1);
        checkOutput("abort grant", 64'(oGrant4), 64'b0010);
        tick(1);
        checkOutput("abort in wait", 64'(oBusy4), 64'd1);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        checkOutput("abort valid", 64'(oValid4), 64'd0);
        checkOutput("abort grant clr", 64'(oGrant4), 64'd0);
        checkOutput("abort mulA", 64'(oMulA4), 64'd0);
        checkOutput("abort mulB", 64'(oMulB4), 64'd0);
        checkOutput("abort result", 64'(oResult4), 64'd0);
        checkOutput("abort id", 64'(oId4), 64'd0);
        checkOutput("abort busy", 64'(oBusy4), 64'd0);
        tick(1);
        checkOutput("post-reset grant", 64'(oGrant4), 64'b0001);
        for (int c = 0; c < 3; c++) begin
            tick(1);
            checkOutput("aborted never valid", 64'(oValid4), 64'd0);
        end
        iReq = 4'd0;
        tick(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mult_rr_arbiter.md
# mult_rr_arbiter

Round-robin arbiter and sequencer that shares one combinational array multiplier (SIZE x SIZE -> 2*SIZE) among four requesters. It registers the winning operand pair onto the multiplier inputs and waits a programmable number of cycles for the ripple array to settle. It then captures the product into a result register held under a valid/ack handshake. It sits between the requesting datapath blocks and the single shared multiplier instance.

## Interface
- SIZE, 16, operand width; the product is 2*SIZE.
- MUL_CYCLES, 1, settle cycles allowed for the multiplier (multicycle path); legal range 1..255, 0 illegal.
- Clock  in  1  system clock, all state updates on posedge.
- Reset  in  1  reset Reset, synchronous, active-high; clock Clock.
- iReq  in  4  per-requester request level; requester holds high with stable operands until it sees its grant.
- iOpA  in  4*SIZE  packed multiplicand A; requester k on bits [k*SIZE +: SIZE].
- iOpB  in  4*SIZE  packed multiplicand B, same packing.
- oGrant  out  4  one-hot, single-cycle pulse: operands of that requester were accepted.
- oMulA  out  SIZE  registered operand A to the multiplier.
- oMulB  out  SIZE  registered operand B to the multiplier.
- iMulR  in  2*SIZE  multiplier product.
- oResult  out  2*SIZE  captured product.
- oId  out  2  index of the requester that owns oResult / the operation in flight.
- oValid  out  1  oResult/oId valid; held until acknowledged.
- iAck  in  1  consumer accepts the result; effective only while oValid=1.
- oBusy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, WAIT, DONE.
- Priority pointer `last` (2 bits) holds the last granted index. Search order is last+1, last+2, last+3, last mod 4. The first asserted iReq in that order wins.
- IDLE, no iReq:
  - Stay in IDLE.
  - Outputs hold their values, except oGrant, which is 0.
- IDLE, any iReq:
  - Load the winner's iOpA slice into oMulA and its iOpB slice into oMulB.
  - Set oId to the winner index and `last` to the winner.
  - Set oGrant to the winner's one-hot for exactly one cycle.
  - Load the settle counter with MUL_CYCLES-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the edge where the counter is 0, capture oResult <= iMulR, set oValid to 1 and go to DONE.
  - WAIT therefore lasts exactly MUL_CYCLES cycles.
- DONE:
  - oValid is held at 1; oResult and oId are stable.
  - On an edge with iAck=1, clear oValid and go to IDLE.
  - While iAck=0, stay in DONE and issue no new grant, regardless of iReq.
- iReq is ignored outside IDLE. No requests are queued; a requester keeps its request asserted and gets served in a later IDLE.
- oMulA and oMulB stay stable from the grant until the next grant. The multiplier output therefore stays valid through DONE.
- Arithmetic is unsigned. The 2*SIZE product cannot overflow, and no truncation is applied.
- iAck while oValid=0 has no effect.

## Timing
- Reset values:
  - oGrant = 0, oMulA = 0, oMulB = 0, oResult = 0, oId = 0, oValid = 0, oBusy = 0.
  - State = IDLE, counter = 0, `last` = 3, so requester 0 has top priority first.
- Let E0 be the grant edge:
  - oGrant and oBusy are visible in the cycle after E0.
  - oValid rises after edge E0+MUL_CYCLES.
- iAck sampled in the first oValid cycle retires the result at that edge. With MUL_CYCLES=1 and an immediate ack, back-to-back service takes 3 cycles per operation (IDLE, WAIT, DONE).
- The requester sees its oGrant pulse in the cycle after E0 and may change operands or drop iReq from the next edge on.
- Reset asserted in any state aborts the operation at that edge:
  - oValid is never raised for the aborted operation.
  - All outputs and `last` return to their reset values.
- Simultaneous requests are resolved only by the pointer. A requester that was just served has the lowest priority in the next arbitration.

## Test plan
- Single request: iReq=4'b0010, A1=16'd300, B1=16'd7, MUL_CYCLES=1, iAck held at 1.
  - Required: oGrant=4'b0010 one cycle after the edge.
  - Required: oValid one cycle later with oResult=32'd2100 and oId=1.
- All four requesting continuously with operands k+1 and 2: grants in order 0,1,2,3,0, with oResult 2, 4, 6, 8 tagged with oId 0..3.
- Fairness: serve requester 2, then assert iReq=4'b1001. Requester 3 is granted before requester 0.
- Backpressure: hold iAck=0 for 5 cycles in DONE while iReq=4'b1111.
  - Required: oValid, oResult and oId stay stable, with no oGrant pulse.
  - Required: the next grant goes out on the first IDLE after iAck.
- Settle and width: MUL_CYCLES=4, A=B=16'hFFFF.
  - Required: oValid rises exactly 4 edges after the grant.
  - Required: oResult=32'hFFFE0001.
- Reset mid-operation: assert Reset during the second WAIT cycle.
  - Required: oValid stays 0 and all outputs return to reset values.
  - Required: with iReq=4'b1111 after reset, the next grant goes to requester 0.
